// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      ACK
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   // Pick a port among live requests; a tie goes to the port not served last.
   function automatic logic pick_port(input logic req_a, input logic req_b, input logic last);
      if (req_a && req_b) begin
         return ~last;
      end else if (req_a) begin
         return PORT_A;
      end else begin
         return PORT_B;
      end
   endfunction

endpackage

// File: rtl/sram_arb.sv
// Two-port arbiter and strobe sequencer for a 256Kx16 asynchronous SRAM
// used as 512 KB of byte-wide memory. Every output is a register.
module sram_arb
   import sram_arb_pkg::*;
#(
   parameter int WAIT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [18:0] a_addr,
   input  logic [7:0]  a_di,
   output logic [7:0]  a_do,
   output logic        a_ack,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [18:0] b_addr,
   input  logic [7:0]  b_di,
   output logic [7:0]  b_do,
   output logic        b_ack,
   output logic [17:0] sram_a,
   input  logic [15:0] sram_dq_i,
   output logic [15:0] sram_dq_o,
   output logic        sram_dq_oe,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);

   localparam logic [2:0] WAIT_CNT = 3'(WAIT);

   state_t      state;
   logic        grant;
   logic        last_grant;
   logic        lat_we;
   logic        lat_lane;
   logic [2:0]  wait_cnt;
   logic        mask_valid;
   logic        mask_port;

   logic        a_live;
   logic        b_live;
   logic        next_grant;
   logic        sel_we;
   logic [18:0] sel_addr;
   logic [7:0]  sel_di;
   logic [7:0]  lane_byte;

   // The port served in the previous transaction is ignored for one IDLE cycle.
   assign a_live = a_req && !(mask_valid && (mask_port == PORT_A));
   assign b_live = b_req && !(mask_valid && (mask_port == PORT_B));

   // Steer the winning port's request fields toward the latch point.
   always_comb begin
      next_grant = pick_port(a_live, b_live, last_grant);
      sel_we     = (next_grant == PORT_A) ? a_we   : b_we;
      sel_addr   = (next_grant == PORT_A) ? a_addr : b_addr;
      sel_di     = (next_grant == PORT_A) ? a_di   : b_di;
      lane_byte  = lat_lane ? sram_dq_i[15:8] : sram_dq_i[7:0];
   end

   // Sequencer: IDLE grants and latches, SETUP opens the chip, STROBE holds
   // OE_N or WE_N low for WAIT cycles, ACK closes the chip and pulses ack.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant      <= PORT_A;
         last_grant <= PORT_B;
         lat_we     <= 1'b0;
         lat_lane   <= 1'b0;
         wait_cnt   <= 3'd0;
         mask_valid <= 1'b0;
         mask_port  <= PORT_A;
         a_do       <= 8'h00;
         a_ack      <= 1'b0;
         b_do       <= 8'h00;
         b_ack      <= 1'b0;
         sram_a     <= 18'h00000;
         sram_dq_o  <= 16'h0000;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_ub_n  <= 1'b1;
         sram_lb_n  <= 1'b1;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         case (state)
            IDLE: begin
               mask_valid <= 1'b0;
               if (a_live || b_live) begin
                  grant      <= next_grant;
                  lat_we     <= sel_we;
                  lat_lane   <= sel_addr[0];
                  sram_a     <= sel_addr[18:1];
                  sram_dq_o  <= {sel_di, sel_di};
                  sram_dq_oe <= sel_we;
                  sram_ce_n  <= 1'b0;
                  sram_ub_n  <= ~sel_addr[0];
                  sram_lb_n  <= sel_addr[0];
                  state      <= SETUP;
               end
            end
            SETUP: begin
               if (lat_we) begin
                  sram_we_n <= 1'b0;
               end else begin
                  sram_oe_n <= 1'b0;
               end
               wait_cnt <= 3'd1;
               state    <= STROBE;
            end
            STROBE: begin
               if (wait_cnt == WAIT_CNT) begin
                  sram_oe_n  <= 1'b1;
                  sram_we_n  <= 1'b1;
                  sram_ce_n  <= 1'b1;
                  sram_ub_n  <= 1'b1;
                  sram_lb_n  <= 1'b1;
                  sram_dq_oe <= 1'b0;
                  if (grant == PORT_A) begin
                     a_ack <= 1'b1;
                     if (!lat_we) begin
                        a_do <= lane_byte;
                     end
                  end else begin
                     b_ack <= 1'b1;
                     if (!lat_we) begin
                        b_do <= lane_byte;
                     end
                  end
                  last_grant <= grant;
                  state      <= ACK;
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            ACK: begin
               mask_valid <= 1'b1;
               mask_port  <= grant;
               wait_cnt   <= 3'd0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: a behavioural SRAM behind the WAIT=1 instance,
// a table of single transactions, then hand-built arbitration, masking,
// reset-abort and WAIT=3 sequences.
module tb_sram_arb;

   logic        clk;
   logic        reset_n;
   logic        a_req, a_we, b_req, b_we;
   logic [18:0] a_addr, b_addr;
   logic [7:0]  a_di, b_di, a_do, b_do;
   logic        a_ack, b_ack;
   logic [17:0] sram_a;
   logic [15:0] sram_dq_i, sram_dq_o;
   logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   logic        w3_a_req, w3_a_we;
   logic [18:0] w3_a_addr;
   logic [7:0]  w3_a_di, w3_a_do, w3_b_do;
   logic        w3_a_ack, w3_b_ack;
   logic [17:0] w3_sram_a;
   logic [15:0] w3_dq_i, w3_dq_o;
   logic        w3_dq_oe, w3_ce_n, w3_oe_n, w3_we_n, w3_ub_n, w3_lb_n;
   logic [7:0]  w3_cnt;

   int tests_run;
   int tests_failed;
   int viol;

   logic [15:0] mem [logic [17:0]];

   typedef struct {
      logic        port;
      logic        we;
      logic [18:0] addr;
      logic [7:0]  di;
      logic [17:0] exp_a;
      logic        exp_ub_n;
      logic        exp_lb_n;
      logic [7:0]  exp_rd;
      logic [15:0] exp_word;
   } vec_t;

   vec_t vecs [7];
   logic [7:0] exp_a_do;
   logic [7:0] exp_b_do;

   sram_arb #(.WAIT(1)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_di(a_di), .a_do(a_do), .a_ack(a_ack),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_di(b_di), .b_do(b_do), .b_ack(b_ack),
      .sram_a(sram_a), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
   );

   sram_arb #(.WAIT(3)) dut3 (
      .clk(clk), .reset_n(reset_n),
      .a_req(w3_a_req), .a_we(w3_a_we), .a_addr(w3_a_addr), .a_di(w3_a_di), .a_do(w3_a_do), .a_ack(w3_a_ack),
      .b_req(1'b0), .b_we(1'b0), .b_addr(19'h00000), .b_di(8'h00), .b_do(w3_b_do), .b_ack(w3_b_ack),
      .sram_a(w3_sram_a), .sram_dq_i(w3_dq_i), .sram_dq_o(w3_dq_o), .sram_dq_oe(w3_dq_oe),
      .sram_ce_n(w3_ce_n), .sram_oe_n(w3_oe_n), .sram_we_n(w3_we_n),
      .sram_ub_n(w3_ub_n), .sram_lb_n(w3_lb_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_read(input logic [17:0] a);
      return mem.exists(a) ? mem[a] : 16'hDEAD;
   endfunction

   // Asynchronous SRAM read path for the main instance.
   always @(sram_a or sram_oe_n or sram_ce_n) begin
      sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem_read(sram_a) : 16'h0000;
   end

   // SRAM write: enabled lanes take the bus while CE_N and WE_N are low.
   always @(posedge clk) begin
      logic [15:0] w;
      if (reset_n && !sram_ce_n && !sram_we_n) begin
         w = mem_read(sram_a);
         if (!sram_lb_n) w[7:0] = sram_dq_o[7:0];
         if (!sram_ub_n) w[15:8] = sram_dq_o[15:8];
         mem[sram_a] = w;
      end
   end

   // WAIT=3 instance sees a byte that counts the OE_N-low cycles.
   always @(posedge clk) begin
      w3_cnt <= w3_oe_n ? 8'd1 : w3_cnt + 8'd1;
   end
   assign w3_dq_i = w3_oe_n ? 16'h0000 : {8'hC0, w3_cnt};

   // Strobe overlap and bus-drive-during-read watch on both instances.
   always @(negedge clk) begin
      if (!sram_oe_n && !sram_we_n) viol++;
      if (sram_dq_oe && !sram_oe_n) viol++;
      if (!w3_oe_n && !w3_we_n) viol++;
      if (w3_dq_oe && !w3_oe_n) viol++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      int          lat;
      int          oe_cnt;
      int          we_cnt;
      logic        seen;
      logic        other_ack;
      logic [17:0] a_s;
      logic        ub_s, lb_s;
      logic [15:0] dq_s;
      lat = 0; oe_cnt = 0; we_cnt = 0; seen = 1'b0; other_ack = 1'b0;
      a_s = '0; ub_s = 1'b1; lb_s = 1'b1; dq_s = '0;
      if (v.port == 1'b0) begin
         a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_di = v.di;
      end else begin
         b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_di = v.di;
      end
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (!sram_ce_n && !seen) begin
            seen = 1'b1; a_s = sram_a; ub_s = sram_ub_n; lb_s = sram_lb_n; dq_s = sram_dq_o;
         end
         if (!sram_oe_n) oe_cnt++;
         if (!sram_we_n) we_cnt++;
         if ((v.port == 1'b0) ? b_ack : a_ack) other_ack = 1'b1;
         if ((v.port == 1'b0) ? a_ack : b_ack) begin
            lat = c;
            a_req = 1'b0;
            b_req = 1'b0;
            break;
         end
      end
      @(negedge clk);
      @(negedge clk);
      checkOutput("latency", lat, 3);
      checkOutput("sram_a", a_s, v.exp_a);
      checkOutput("ub_n", ub_s, v.exp_ub_n);
      checkOutput("lb_n", lb_s, v.exp_lb_n);
      checkOutput("other_ack", other_ack, 1'b0);
      if (v.we) begin
         checkOutput("we_cycles", we_cnt, 1);
         checkOutput("oe_cycles_wr", oe_cnt, 0);
         checkOutput("dq_o", dq_s, {v.di, v.di});
         checkOutput("mem_word", mem_read(v.exp_a), v.exp_word);
      end else begin
         checkOutput("oe_cycles", oe_cnt, 1);
         checkOutput("we_cycles_rd", we_cnt, 0);
         if (v.port == 1'b0) exp_a_do = v.exp_rd;
         else                exp_b_do = v.exp_rd;
      end
      checkOutput("a_do", a_do, exp_a_do);
      checkOutput("b_do", b_do, exp_b_do);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int   a_n, b_n, n, cnt;
      logic [7:0] order [6];
      int   when [6];
      logic flag, flag2;

      tests_run = 0; tests_failed = 0; viol = 0;
      exp_a_do = 8'h00; exp_b_do = 8'h00;
      a_req = 0; a_we = 0; a_addr = '0; a_di = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_di = '0;
      w3_a_req = 0; w3_a_we = 0; w3_a_addr = '0; w3_a_di = '0;
      mem[18'h00010] = 16'h1234;
      mem[18'h3FFFF] = 16'h9999;

      vecs[0] = '{1'b0, 1'b0, 19'h00021, 8'h00, 18'h00010, 1'b0, 1'b1, 8'h12, 16'h0000};
      vecs[1] = '{1'b0, 1'b0, 19'h00020, 8'h00, 18'h00010, 1'b1, 1'b0, 8'h34, 16'h0000};
      vecs[2] = '{1'b1, 1'b1, 19'h7FFFE, 8'hA5, 18'h3FFFF, 1'b1, 1'b0, 8'h00, 16'h99A5};
      vecs[3] = '{1'b1, 1'b0, 19'h7FFFE, 8'h00, 18'h3FFFF, 1'b1, 1'b0, 8'hA5, 16'h0000};
      vecs[4] = '{1'b0, 1'b1, 19'h00021, 8'h77, 18'h00010, 1'b0, 1'b1, 8'h00, 16'h7734};
      vecs[5] = '{1'b0, 1'b0, 19'h00021, 8'h00, 18'h00010, 1'b0, 1'b1, 8'h77, 16'h0000};
      vecs[6] = '{1'b1, 1'b0, 19'h7FFFF, 8'h00, 18'h3FFFF, 1'b0, 1'b1, 8'h99, 16'h0000};

      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_a_ack", a_ack, 1'b0);
      checkOutput("rst_b_ack", b_ack, 1'b0);
      checkOutput("rst_a_do", a_do, 8'h00);
      checkOutput("rst_b_do", b_do, 8'h00);
      checkOutput("rst_sram_a", sram_a, 18'h0);
      checkOutput("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
      checkOutput("rst_dq_oe", sram_dq_oe, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
      end

      // Both ports saturated: expect A,B,A,B,A,B every 4 cycles.
      a_n = 0; b_n = 0; n = 0;
      a_we = 0; a_addr = 19'h00020; b_we = 0; b_addr = 19'h7FFFF;
      a_req = 1; b_req = 1;
      for (int c = 1; c <= 60 && n < 6; c++) begin
         @(negedge clk);
         if (a_ack) begin
            order[n] = "A"; when[n] = c; n++; a_n++;
            if (a_n == 3) a_req = 0;
         end
         if (b_ack) begin
            order[n] = "B"; when[n] = c; n++; b_n++;
            if (b_n == 3) b_req = 0;
         end
      end
      a_req = 0; b_req = 0;
      checkOutput("alt_count", n, 6);
      if (n == 6) begin
         checkOutput("alt_first", when[0], 3);
         for (int i = 0; i < 6; i++) begin
            checkOutput("alt_order", order[i], (i % 2 == 0) ? 8'h41 : 8'h42);
            if (i > 0) checkOutput("alt_period", when[i] - when[i-1], 4);
         end
      end
      checkOutput("alt_a_do", a_do, 8'h34);
      checkOutput("alt_b_do", b_do, 8'h99);
      repeat (3) @(negedge clk);

      // A holds req through the masked IDLE cycle: no second transaction.
      a_we = 0; a_addr = 19'h00021; a_req = 1;
      cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (a_ack) begin cnt = c; break; end
      end
      checkOutput("mask_latency", cnt, 3);
      @(negedge clk);
      @(negedge clk);
      a_req = 0;
      flag = 1'b0; flag2 = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (!sram_ce_n) flag = 1'b1;
         if (a_ack) flag2 = 1'b1;
      end
      checkOutput("mask_no_ce", flag, 1'b0);
      checkOutput("mask_no_ack", flag2, 1'b0);

      // Reset dropped during the write strobe abandons the transaction.
      b_we = 1; b_addr = 19'h00002; b_di = 8'h55; b_req = 1;
      flag = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (!sram_we_n) begin flag = 1'b1; break; end
      end
      checkOutput("abort_we_seen", flag, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
      checkOutput("abort_dq_oe", sram_dq_oe, 1'b0);
      checkOutput("abort_sram_a", sram_a, 18'h0);
      checkOutput("abort_a_do", a_do, 8'h00);
      checkOutput("abort_b_do", b_do, 8'h00);
      b_req = 0;
      flag = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (a_ack || b_ack) flag = 1'b1;
      end
      checkOutput("abort_no_ack", flag, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      a_we = 0; a_addr = 19'h00021; b_we = 0; b_addr = 19'h7FFFF;
      a_req = 1; b_req = 1;
      cnt = 0; flag = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin cnt = c; flag = a_ack; a_req = 0; break; end
      end
      checkOutput("post_rst_tie_a", flag, 1'b1);
      checkOutput("post_rst_latency", cnt, 3);
      cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (b_ack) begin cnt = c; b_req = 0; break; end
      end
      checkOutput("post_rst_b_after", cnt, 4);
      b_req = 0;
      repeat (3) @(negedge clk);

      // WAIT=3: OE_N low three cycles, ack in cycle 5, last-edge data.
      w3_a_we = 0; w3_a_addr = 19'h00000; w3_a_req = 1;
      cnt = 0; n = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (!w3_oe_n) n++;
         if (w3_a_ack) begin cnt = c; w3_a_req = 0; break; end
      end
      w3_a_req = 0;
      checkOutput("w3_oe_cycles", n, 3);
      checkOutput("w3_latency", cnt, 5);
      checkOutput("w3_a_do", w3_a_do, 8'h03);
      checkOutput("w3_lane_ub", w3_ub_n, 1'b1);
      repeat (2) @(negedge clk);

      checkOutput("strobe_overlap", viol, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
